// File: rtl/train_pkg.sv
// Shared types for the perceptron training feeder: FSM states, sample layout
// and target encoding.
package train_pkg;

    localparam int X_W      = 7;
    localparam int T_W      = 2;
    localparam int SAMPLE_W = 2 * X_W + T_W;

    localparam logic signed [T_W-1:0] T_POS = 2'sb01;
    localparam logic signed [T_W-1:0] T_NEG = 2'sb11;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EVAL,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [X_W-1:0] x1;
        logic signed [X_W-1:0] x2;
        logic [T_W-1:0]        t;
    } sample_t;

    // Targets are forced to +1/-1; only the sign bit of the loaded target matters.
    function automatic logic [T_W-1:0] norm_target(input logic neg);
        return neg ? T_NEG : T_POS;
    endfunction

endpackage

// File: rtl/sample_store.sv
// Training-sample buffer: DEPTH x 16-bit register array with synchronous write
// at the fill pointer, asynchronous read and a clearable sample count.
module sample_store
    import train_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                clear,
    input  logic [AW-1:0]       rd_idx,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic [CW-1:0]       count
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (wr_en && count < CW'(DEPTH))
            count <= count + CW'(1);
    end

    // Contents need no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en && !clear && count < CW'(DEPTH))
            mem[count[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/train_sample_feeder.sv
// Replays a stored training set into the perceptron datapath epoch by epoch,
// pulsing weight updates on misclassification. TRAIN_ERR_LOG_EN adds last_err.
module train_sample_feeder
    import train_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int MAX_EPOCH = 64,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int EW        = $clog2(MAX_EPOCH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [X_W-1:0] load_x1,
    input  logic [X_W-1:0] load_x2,
    input  logic [T_W-1:0] load_t,
    input  logic           clear,
    input  logic           start,
    output logic [X_W-1:0] x1out,
    output logic [X_W-1:0] x2out,
    output logic [T_W-1:0] tout,
    output logic           ldX1,
    output logic           ldX2,
    output logic           ldT,
    output logic           ldW1,
    output logic           ldW2,
    output logic           ldB,
    output logic           clr_w,
    input  logic           eq,
    output logic           busy,
    output logic           done,
    output logic           converged,
    output logic [EW-1:0]  epoch_cnt
`ifdef TRAIN_ERR_LOG_EN
    ,
    output logic [CW-1:0]  last_err
`endif
);

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [CW-1:0] err_cnt, err_n, err_eval;
    logic [EW-1:0] epoch_n;
    logic          conv_n;
    logic          start_ok, wr_en, store_clear;
    logic [CW-1:0] count;
    logic [SAMPLE_W-1:0] rd_data;
    sample_t       rd_smp;
    logic [X_W-1:0] hold_x1, hold_x2;
    logic [T_W-1:0] hold_t;
`ifdef TRAIN_ERR_LOG_EN
    logic [CW-1:0] last_err_n;
`endif

    sample_store #(.DEPTH(DEPTH)) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({load_x1, load_x2, norm_target(load_t[1])}),
        .clear   (store_clear),
        .rd_idx  (idx),
        .rd_data (rd_data),
        .count   (count)
    );

    assign rd_smp = sample_t'(rd_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            err_cnt   <= '0;
            epoch_cnt <= '0;
            converged <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            err_cnt   <= err_n;
            epoch_cnt <= epoch_n;
            converged <= conv_n;
        end
    end

`ifdef TRAIN_ERR_LOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_err <= '0;
        else
            last_err <= last_err_n;
    end
`endif

    // Datapath inputs are transparent during FETCH and hold the last sample otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_x1 <= '0;
            hold_x2 <= '0;
            hold_t  <= T_POS;
        end else if (state == FETCH) begin
            hold_x1 <= rd_smp.x1;
            hold_x2 <= rd_smp.x2;
            hold_t  <= rd_smp.t;
        end
    end

    assign x1out = (state == FETCH) ? rd_smp.x1 : hold_x1;
    assign x2out = (state == FETCH) ? rd_smp.x2 : hold_x2;
    assign tout  = (state == FETCH) ? rd_smp.t  : hold_t;
    assign clr_w = start_ok & rst;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        err_n       = err_cnt;
        epoch_n     = epoch_cnt;
        conv_n      = converged;
`ifdef TRAIN_ERR_LOG_EN
        last_err_n  = last_err;
`endif
        start_ok    = 1'b0;
        wr_en       = 1'b0;
        store_clear = 1'b0;
        load_ready  = 1'b0;
        ldX1 = 1'b0; ldX2 = 1'b0; ldT = 1'b0;
        ldW1 = 1'b0; ldW2 = 1'b0; ldB = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err_eval    = err_cnt;
        if (!eq && err_cnt != CW'(DEPTH))
            err_eval = err_cnt + CW'(1);

        case (state)
            IDLE: begin
                load_ready = (count < CW'(DEPTH)) && !start && !clear;
                wr_en      = load_valid && load_ready;
                if (clear)
                    store_clear = 1'b1;
                else if (start)
                    start_ok = 1'b1;
            end
            FETCH: begin
                busy    = 1'b1;
                ldX1    = 1'b1;
                ldX2    = 1'b1;
                ldT     = 1'b1;
                state_n = EVAL;
            end
            EVAL: begin
                busy = 1'b1;
                ldW1 = !eq;
                ldW2 = !eq;
                ldB  = !eq;
                if (CW'(idx) + CW'(1) < count) begin
                    idx_n   = idx + AW'(1);
                    err_n   = err_eval;
                    state_n = FETCH;
                end else begin
                    epoch_n = epoch_cnt + EW'(1);
`ifdef TRAIN_ERR_LOG_EN
                    last_err_n = err_eval;
`endif
                    if (err_eval == '0) begin
                        conv_n  = 1'b1;
                        state_n = DONE;
                    end else if (epoch_cnt + EW'(1) == EW'(MAX_EPOCH)) begin
                        conv_n  = 1'b0;
                        state_n = DONE;
                    end else begin
                        idx_n   = '0;
                        err_n   = '0;
                        state_n = FETCH;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (clear)
                    state_n = IDLE;
                else if (start)
                    start_ok = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (start_ok) begin
            idx_n   = '0;
            err_n   = '0;
            epoch_n = '0;
            conv_n  = 1'b0;
            state_n = (count == '0) ? DONE : FETCH;
        end
    end

endmodule

// File: tb/tb_train_sample_feeder.sv
// Scoreboard bench for train_sample_feeder with a behavioural perceptron
// datapath attached (DEPTH=4, MAX_EPOCH=8).
module tb_train_sample_feeder;

    localparam int DEPTH     = 4;
    localparam int MAX_EPOCH = 8;
    localparam int GUARD     = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0, load_ready;
    logic [6:0] load_x1 = '0, load_x2 = '0;
    logic [1:0] load_t = 2'b01;
    logic       clear = 1'b0, start = 1'b0;
    logic [6:0] x1out, x2out;
    logic [1:0] tout;
    logic       ldX1, ldX2, ldT, ldW1, ldW2, ldB, clr_w, eq;
    logic       busy, done, converged;
    logic [3:0] epoch_cnt;
`ifdef TRAIN_ERR_LOG_EN
    logic [2:0] last_err;
`endif

    train_sample_feeder #(.DEPTH(DEPTH), .MAX_EPOCH(MAX_EPOCH)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_x1(load_x1), .load_x2(load_x2), .load_t(load_t),
        .clear(clear), .start(start),
        .x1out(x1out), .x2out(x2out), .tout(tout),
        .ldX1(ldX1), .ldX2(ldX2), .ldT(ldT),
        .ldW1(ldW1), .ldW2(ldW2), .ldB(ldB), .clr_w(clr_w),
        .eq(eq), .busy(busy), .done(done), .converged(converged),
        .epoch_cnt(epoch_cnt)
`ifdef TRAIN_ERR_LOG_EN
        , .last_err(last_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural perceptron datapath: sign(w1*x1 + w2*x2 + b) compared to target.
    int  dp_x1 = 0, dp_x2 = 0, dp_t = 1, w1 = 0, w2 = 0, wb = 0;
    int  dp_sum, dp_pred;
    bit  eq_tie = 1'b0;

    always @(posedge clk) begin
        if (clr_w) begin
            w1 <= 0; w2 <= 0; wb <= 0;
        end else begin
            if (ldW1) w1 <= w1 + dp_t * dp_x1;
            if (ldW2) w2 <= w2 + dp_t * dp_x2;
            if (ldB)  wb <= wb + dp_t;
        end
        if (ldX1) dp_x1 <= int'($signed(x1out));
        if (ldX2) dp_x2 <= int'($signed(x2out));
        if (ldT)  dp_t  <= tout[1] ? -1 : 1;
    end

    always_comb begin
        dp_sum  = w1 * dp_x1 + w2 * dp_x2 + wb;
        dp_pred = (dp_sum >= 0) ? 1 : -1;
        eq      = eq_tie ? 1'b1 : (dp_pred == dp_t);
    end

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] smp;
        logic        ldw;
    } exp_t;

    exp_t       sb[$];
    int         bx1[$], bx2[$];
    logic [1:0] bt[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int x1, input int x2, input logic [1:0] t);
        logic exp_ready;
        @(negedge clk);
        load_valid = 1'b1;
        load_x1    = 7'(x1);
        load_x2    = 7'(x2);
        load_t     = t;
        exp_ready  = (bx1.size() < DEPTH);
        #1;
        checkOutput("load_ready", load_ready, exp_ready);
        if (exp_ready) begin
            bx1.push_back(x1);
            bx2.push_back(x2);
            bt.push_back({t[1], 1'b1});
        end
    endtask

    task automatic endLoad();
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic doClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic forgetSamples();
        bx1.delete();
        bx2.delete();
        bt.delete();
    endtask

    task automatic runTraining(input bit tie);
        int   n, m1, m2, mb, tv, sum, pred, errs, ep, busy_exp;
        int   busy_seen, ldx_seen, clr_extra, guard;
        bit   conv, ok;
        exp_t cur;
        n = bx1.size();
        m1 = 0; m2 = 0; mb = 0; ep = 0; conv = 1'b0;
        sb.delete();
        if (n > 0) begin
            while (1) begin
                errs = 0;
                for (int i = 0; i < n; i++) begin
                    tv   = bt[i][1] ? -1 : 1;
                    sum  = m1 * bx1[i] + m2 * bx2[i] + mb;
                    pred = (sum >= 0) ? 1 : -1;
                    ok   = tie || (pred == tv);
                    sb.push_back('{smp: {7'(bx1[i]), 7'(bx2[i]), bt[i]}, ldw: !ok});
                    if (!ok) begin
                        m1 += tv * bx1[i];
                        m2 += tv * bx2[i];
                        mb += tv;
                        errs++;
                    end
                end
                ep++;
                if (errs == 0) begin
                    conv = 1'b1;
                    break;
                end
                if (ep == MAX_EPOCH) break;
            end
        end
        busy_exp = 2 * n * ep;
        eq_tie   = tie;

        @(negedge clk);
        start = 1'b1;
        #1;
        checkOutput("clr_w_pulse", clr_w, 1);
        busy_seen = 0; ldx_seen = 0; clr_extra = 0; guard = 0;
        cur = '0;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            guard++;
            if (done || guard > GUARD) break;
            if (clr_w) clr_extra++;
            if (busy) busy_seen++;
            if (ldX1) begin
                ldx_seen++;
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    checkOutput("sample", {x1out, x2out, tout}, cur.smp);
                    checkOutput("ldx_group", {ldX2, ldT}, 2'b11);
                end
            end else if (busy) begin
                checkOutput("ldw", {ldW1, ldW2, ldB}, {3{cur.ldw}});
            end
        end
        checkOutput("train_timeout", guard <= GUARD, 1);
        checkOutput("done", done, 1);
        checkOutput("converged", converged, conv);
        checkOutput("epoch_cnt", epoch_cnt, ep);
        checkOutput("busy_cycles", busy_seen, busy_exp);
        checkOutput("ldx_count", ldx_seen, n * ep);
        checkOutput("sb_left", sb.size(), 0);
        checkOutput("clr_w_extra", clr_extra, 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_status", {busy, done, converged}, 3'b000);
        checkOutput("rst_strobes", {ldX1, ldX2, ldT, ldW1, ldW2, ldB, clr_w}, 7'b0);
        checkOutput("rst_outputs", {x1out, x2out, tout}, 16'h0001);
        checkOutput("rst_epoch", epoch_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_rst", load_ready, 1);

        // Fill past capacity with the AND set; the fifth sample must be refused
        applyStimulus(-16, -16, 2'b10);
        applyStimulus(-16,  16, 2'b11);
        applyStimulus( 16, -16, 2'b11);
        applyStimulus( 16,  16, 2'b00);
        applyStimulus(  5,   5, 2'b01);
        endLoad();

        runTraining(1'b0);
        checkOutput("ready_in_done", load_ready, 0);

        // XOR set cannot converge and must stop at the epoch limit
        doClear();
        doClear();
        forgetSamples();
        applyStimulus(-16, -16, 2'b11);
        applyStimulus(-16,  16, 2'b01);
        applyStimulus( 16, -16, 2'b01);
        applyStimulus( 16,  16, 2'b11);
        endLoad();
        runTraining(1'b0);

        // eq tied high: one clean epoch, no weight strobes
        doClear();
        doClear();
        forgetSamples();
        applyStimulus(3, -7, 2'b01);
        applyStimulus(-60, 63, 2'b11);
        applyStimulus(-64, 0, 2'b01);
        endLoad();
        runTraining(1'b1);

        // clear and start together in IDLE: clear wins
        doClear();
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        #1;
        checkOutput("clr_w_blocked", clr_w, 0);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("clear_wins", {busy, done}, 2'b00);
        forgetSamples();

        // Empty store start
        runTraining(1'b0);

        // Reset in the middle of EVAL
        doClear();
        applyStimulus(-16, -16, 2'b11);
        applyStimulus(-16,  16, 2'b01);
        applyStimulus( 16, -16, 2'b01);
        applyStimulus( 16,  16, 2'b11);
        endLoad();
        eq_tie = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("mid_fetch", ldX1, 1);
        @(negedge clk);
        #1;
        checkOutput("mid_eval_ldw", {ldW1, ldW2, ldB}, 3'b111);
        rst = 1'b0;
        #1;
        checkOutput("rst_drops_strobes", {ldX1, ldX2, ldT, ldW1, ldW2, ldB, clr_w, busy}, 8'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_mid_rst", load_ready, 1);
        checkOutput("done_after_mid_rst", done, 0);
        checkOutput("epoch_after_mid_rst", epoch_cnt, 0);
        forgetSamples();
        runTraining(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
